// File: rtl/dmem_read_arbiter.sv
// dmem_read_arbiter: shares the data_mem read port between CPU loads and an AXI-Lite read slave
// with fixed CPU priority and AXI anti-starvation; AXI_ADDR_CHECK_EN adds SLVERR for bad addresses.
module dmem_read_arbiter #(
    parameter int MEM_BYTES    = 4096,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    typedef enum logic [1:0] {AX_IDLE, AX_WAIT, AX_READ, AX_RESP} ax_state_t;
    ax_state_t state, state_nx;
    logic [CW-1:0] starve_cnt;
    logic [31:0] ar_addr;
    logic axi_pend, axi_gnt, ar_hs, addr_err;
`ifdef AXI_ADDR_CHECK_EN
    assign addr_err = (|s_axi_araddr[1:0]) || (s_axi_araddr >= 32'(MEM_BYTES));
`else
    assign addr_err = 1'b0;
`endif
    assign cpu_rdata = mem_rdata;
    always_comb begin
        axi_pend      = state == AX_WAIT;
        axi_gnt       = axi_pend && (!cpu_req || starve_cnt == CW'(STARVE_LIMIT));
        cpu_gnt       = cpu_req && !axi_gnt;
        mem_en        = cpu_gnt || axi_gnt;
        mem_addr      = axi_gnt ? ar_addr : cpu_gnt ? cpu_addr : 32'h0;
        s_axi_arready = rst_n && state == AX_IDLE;
        s_axi_rvalid  = state == AX_RESP;
        ar_hs         = s_axi_arvalid && s_axi_arready;
        state_nx      = state;
        case (state)
            AX_IDLE: state_nx = ar_hs ? (addr_err ? AX_RESP : AX_WAIT) : AX_IDLE;
            AX_WAIT: state_nx = axi_gnt ? AX_READ : AX_WAIT;
            AX_READ: state_nx = AX_RESP;
            AX_RESP: state_nx = s_axi_rready ? AX_IDLE : AX_RESP;
            default: state_nx = AX_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= AX_IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt  <= '0;
            cpu_rvalid  <= 1'b0;
            ar_addr     <= 32'h0;
            s_axi_rdata <= 32'h0;
            s_axi_rresp <= 2'b00;
        end else begin
            cpu_rvalid <= cpu_gnt;
            // count only CPU wins that actually held off a waiting AXI read; saturate at the limit
            starve_cnt <= (!axi_pend || axi_gnt) ? '0 :
                          (cpu_gnt && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + CW'(1) : starve_cnt;
            if (ar_hs) ar_addr <= s_axi_araddr;
            if (ar_hs && addr_err) begin
                s_axi_rdata <= 32'h0;
                s_axi_rresp <= 2'b10;
            end else if (state == AX_READ) begin
                s_axi_rdata <= mem_rdata;
                s_axi_rresp <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_dmem_read_arbiter.sv
// tb_dmem_read_arbiter: scoreboard bench for dmem_read_arbiter with a 1-cycle synchronous memory model.
module tb_dmem_read_arbiter;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        cpu_req = 1'b0, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr = 32'h0, cpu_rdata;
    logic [31:0] s_axi_araddr = 32'h0, s_axi_rdata;
    logic        s_axi_arvalid = 1'b0, s_axi_arready, s_axi_rvalid, s_axi_rready = 1'b1;
    logic [1:0]  s_axi_rresp;
    logic        mem_en;
    logic [31:0] mem_addr, mem_rdata = 32'h0;
    logic [31:0] mem [1024];
    logic [33:0] exp_q [$];
    int errors = 0, checks = 0;

    dmem_read_arbiter #(.MEM_BYTES(4096), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[11:2]];

    function automatic logic [31:0] wexp(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    task automatic do_ar(input logic [31:0] a, input logic [33:0] e);
        @(negedge clk);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_rvalid && n < 20);
    endtask

    task automatic pop_exp(output logic [33:0] e);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 34'bx;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got arready=%b rvalid=%b exp 0 0", s_axi_arready, s_axi_rvalid);
        end
        checks++;
        if ({s_axi_rresp, s_axi_rdata} !== 34'h0 || cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got rresp=%h rdata=%h cpu_rvalid=%b mem_en=%b exp all 0",
                     s_axi_rresp, s_axi_rdata, cpu_rvalid, mem_en);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got arready=%b exp 1", s_axi_arready);
        end
    endtask

    task automatic test_axi_basic;
        logic [31:0] addrs [4] = '{32'h10, 32'h44, 32'h88, 32'hFFC};
        logic [33:0] e;
        int n;
        foreach (addrs[i]) begin
            do_ar(addrs[i], {2'b00, wexp(addrs[i])});
            wait_rvalid(n);
            checks++;
            if (n !== 3) begin
                errors++;
                $display("FAIL axi_latency addr=%h got=%0d exp=3", addrs[i], n);
            end
            pop_exp(e);
            checks++;
            if ({s_axi_rresp, s_axi_rdata} !== e) begin
                errors++;
                $display("FAIL axi_data addr=%h got=%h/%h exp=%h/%h", addrs[i], s_axi_rresp, s_axi_rdata, e[33:32], e[31:0]);
            end
            @(negedge clk);
            checks++;
            if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
                errors++;
                $display("FAIL axi_idle got rvalid=%b arready=%b exp 0 1", s_axi_rvalid, s_axi_arready);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic [33:0] e;
        int n;
        s_axi_rready = 1'b0;
        do_ar(32'h20, {2'b00, wexp(32'h20)});
        wait_rvalid(n);
        d = s_axi_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== d || s_axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got rvalid=%b rdata=%h arready=%b exp 1 %h 0",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_arready, d);
            end
        end
        s_axi_rready = 1'b1;
        pop_exp(e);
        checks++;
        if ({s_axi_rresp, s_axi_rdata} !== e) begin
            errors++;
            $display("FAIL bp_data got=%h/%h exp=%h/%h", s_axi_rresp, s_axi_rdata, e[33:32], e[31:0]);
        end
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got rvalid=%b arready=%b exp 0 1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_contention;
        logic        pg = 1'b0, g;
        logic [31:0] pa = 32'h0, ea;
        logic [33:0] e;
        int n;
        do_ar(32'h50, {2'b00, wexp(32'h50)});
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g  = (i != 4);
            ea = g ? cpu_addr : 32'h50;
            checks++;
            if (cpu_gnt !== g || mem_en !== 1'b1 || mem_addr !== ea) begin
                errors++;
                $display("FAIL contention_gnt cyc=%0d got gnt=%b en=%b addr=%h exp %b 1 %h",
                         i, cpu_gnt, mem_en, mem_addr, g, ea);
            end
            checks++;
            if (cpu_rvalid !== pg || (pg && cpu_rdata !== wexp(pa))) begin
                errors++;
                $display("FAIL contention_cpu cyc=%0d got rvalid=%b rdata=%h exp %b %h",
                         i, cpu_rvalid, cpu_rdata, pg, wexp(pa));
            end
            pg = g;
            pa = cpu_addr;
            @(posedge clk);
            #1 if (g) cpu_addr = cpu_addr + 32'h4;
        end
        cpu_req = 1'b0;
        wait_rvalid(n);
        pop_exp(e);
        checks++;
        if (n > 2 || {s_axi_rresp, s_axi_rdata} !== e) begin
            errors++;
            $display("FAIL contention_axi got=%h/%h after %0d exp=%h/%h within 2",
                     s_axi_rresp, s_axi_rdata, n, e[33:32], e[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        logic [33:0] e;
        int n;
        do_ar(32'h60, {2'b00, wexp(32'h60)});
        cpu_req  = 1'b1;
        cpu_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL simul_gnt got gnt=%b en=%b addr=%h exp 1 1 00000200", cpu_gnt, mem_en, mem_addr);
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== wexp(32'h200)) begin
            errors++;
            $display("FAIL simul_cpu got rvalid=%b rdata=%h exp 1 %h", cpu_rvalid, cpu_rdata, wexp(32'h200));
        end
        wait_rvalid(n);
        pop_exp(e);
        checks++;
        if ({s_axi_rresp, s_axi_rdata} !== e) begin
            errors++;
            $display("FAIL simul_axi got=%h/%h exp=%h/%h", s_axi_rresp, s_axi_rdata, e[33:32], e[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        logic [33:0] e;
        int n;
        do_ar(32'h70, {2'b00, wexp(32'h70)});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_read got rvalid=%b arready=%b cpu_rvalid=%b exp 0 0 0",
                     s_axi_rvalid, s_axi_arready, cpu_rvalid);
        end
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        s_axi_rready = 1'b0;
        do_ar(32'h78, {2'b00, wexp(32'h78)});
        wait_rvalid(n);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_resp got rvalid=%b arready=%b rdata=%h exp 0 0 0",
                     s_axi_rvalid, s_axi_arready, s_axi_rdata);
        end
        exp_q.delete();
        s_axi_rready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        do_ar(32'h74, {2'b00, wexp(32'h74)});
        wait_rvalid(n);
        pop_exp(e);
        checks++;
        if (n !== 3 || {s_axi_rresp, s_axi_rdata} !== e) begin
            errors++;
            $display("FAIL rst_recover got=%h/%h lat=%0d exp=%h/%h lat=3",
                     s_axi_rresp, s_axi_rdata, n, e[33:32], e[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_check;
        logic [31:0] addrs [2] = '{32'h1002, 32'h2000};
        logic [33:0] e;
        logic        seen;
        logic [31:0] ma;
        int n;
        foreach (addrs[i]) begin
`ifdef AXI_ADDR_CHECK_EN
            do_ar(addrs[i], {2'b10, 32'h0});
`else
            do_ar(addrs[i], {2'b00, wexp(addrs[i])});
`endif
            seen = 1'b0;
            ma   = 32'h0;
            n    = 0;
            do begin
                @(negedge clk);
                n++;
                if (mem_en) begin
                    seen = 1'b1;
                    ma   = mem_addr;
                end
            end while (!s_axi_rvalid && n < 20);
            pop_exp(e);
            checks++;
            if ({s_axi_rresp, s_axi_rdata} !== e) begin
                errors++;
                $display("FAIL addr_resp addr=%h got=%h/%h exp=%h/%h", addrs[i], s_axi_rresp, s_axi_rdata, e[33:32], e[31:0]);
            end
`ifdef AXI_ADDR_CHECK_EN
            checks++;
            if (n !== 1 || seen !== 1'b0) begin
                errors++;
                $display("FAIL addr_err_path addr=%h got lat=%0d mem_en_seen=%b exp 1 0", addrs[i], n, seen);
            end
`else
            checks++;
            if (n !== 3 || seen !== 1'b1 || ma !== addrs[i]) begin
                errors++;
                $display("FAIL addr_pass addr=%h got lat=%0d seen=%b mem_addr=%h exp 3 1 %h", addrs[i], n, seen, ma, addrs[i]);
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | (i * 4);
        mem[4] = 32'hDEADBEEF;
        test_reset;
        test_axi_basic;
        test_backpressure;
        test_contention;
        test_simultaneous;
        test_reset_midflight;
        test_addr_check;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
